html_char_streamer: RTL and testbench

//  Character source for html_parser. Reads an HTML document byte-by-byte from a synchronous ROM and drives
//  the parser's char and state_enable inputs, honouring the parser's out_pause. Each character is held until
//  the parser has accepted it. Detects end of document, drains the last render, then drops state_enable.

---
 rtl/html_char_streamer_if.sv | 35 +++
 rtl/html_char_streamer.sv | 122 ++++++++++++
 tb/tb_html_char_streamer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/html_char_streamer_if.sv
// ----------------------------------------------------------------------------
// html_char_streamer_if
// Bundles the streamer's control, ROM and parser-facing signals.
//   start         1-cycle pulse that begins streaming a document
//   pause         parser out_pause; high holds the current character
//   rom_addr      registered ROM address
//   rom_data      ROM output = mem[rom_addr of the previous cycle]
//   character     character presented to the parser's char input
//   state_enable  parser enable (acts as the parser's active-low reset)
//   done          high once the document has been fully consumed
//   char_count    characters accepted by the parser for this document
// Modports: master = streamer side, slave = ROM/parser/controller side.
// ----------------------------------------------------------------------------
interface html_char_streamer_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  start;
   logic                  pause;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [7:0]            rom_data;
   logic [7:0]            character;
   logic                  state_enable;
   logic                  done;
   logic [ADDR_WIDTH:0]   char_count;

   modport master (
      input  start, pause, rom_data,
      output rom_addr, character, state_enable, done, char_count
   );

   modport slave (
      output start, pause, rom_data,
      input  rom_addr, character, state_enable, done, char_count
   );
endinterface

// File: rtl/html_char_streamer.sv
// ----------------------------------------------------------------------------
// html_char_streamer
// Streams an HTML document byte by byte from a synchronous ROM into the
// html_parser. Each character is held for at least MIN_HOLD cycles and until
// the parser is not pausing. On END_CHAR (or after DOC_LENGTH bytes) a space
// is presented while the parser finishes the last render, then state_enable
// drops and done rises.
// Ports:
//   clock   system clock
//   reset   synchronous, active-high reset (wins over all inputs)
//   bus     html_char_streamer_if.master (start, pause, rom_addr, rom_data,
//           character, state_enable, done, char_count)
// ----------------------------------------------------------------------------
module html_char_streamer #(
   parameter int         ADDR_WIDTH = 12,
   parameter int         DOC_LENGTH = 4096,
   parameter logic [7:0] END_CHAR   = 8'h00,
   parameter int         MIN_HOLD   = 2
) (
   input logic                  clock,
   input logic                  reset,
   html_char_streamer_if.master bus
);

   typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

   localparam int                  HOLD_W    = $clog2(MIN_HOLD) + 1;
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
   localparam logic [ADDR_WIDTH:0] DOC_END   = (ADDR_WIDTH + 1)'(DOC_LENGTH);
   localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);
   localparam logic [7:0]          SPACE     = 8'h20;

   state_t                state;
   logic [ADDR_WIDTH-1:0] idx;
   logic [HOLD_W-1:0]     hold;
   logic                  accept;
   logic [ADDR_WIDTH:0]   idx_next;
   logic                  last_char;

   // The parser has taken the current character once it has been shown for
   // MIN_HOLD cycles and the parser is not pausing.
   assign accept    = !bus.pause && (hold == HOLD_LAST);
   // Compared one bit wider so DOC_LENGTH == 2^ADDR_WIDTH is reachable.
   assign idx_next  = {1'b0, idx} + COUNT_ONE;
   assign last_char = (idx_next == DOC_END) || (bus.rom_data == END_CHAR);

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         bus.rom_addr     <= '0;
         bus.character    <= '0;
         bus.state_enable <= 1'b0;
         bus.done         <= 1'b0;
         bus.char_count   <= '0;
         idx              <= '0;
         hold             <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state          <= PRIME;
                  bus.rom_addr   <= '0;
                  bus.done       <= 1'b0;
                  bus.char_count <= '0;
               end
            end
            // rom_addr has been 0 since IDLE/DONE, so rom_data already
            // carries mem[0] during this cycle.
            PRIME: begin
               if (bus.rom_data == END_CHAR) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
               end else begin
                  bus.character    <= bus.rom_data;
                  idx              <= '0;
                  bus.rom_addr     <= ADDR_ONE;
                  hold             <= '0;
                  bus.state_enable <= 1'b1;
                  state            <= STREAM;
               end
            end
            // rom_addr runs one ahead of idx, so rom_data holds the next
            // character by the time the current one is accepted. The fetch
            // after the final index may wrap to 0; it is never consumed.
            STREAM: begin
               if (accept) begin
                  bus.char_count <= bus.char_count + COUNT_ONE;
                  hold           <= '0;
                  if (last_char) begin
                     bus.character <= SPACE;
                     state         <= DRAIN;
                  end else begin
                     bus.character <= bus.rom_data;
                     idx           <= idx + ADDR_ONE;
                     bus.rom_addr  <= idx + ADDR_TWO;
                  end
               end else if (hold != HOLD_LAST) begin
                  hold <= hold + HOLD_ONE;
               end
            end
            // A space is harmless if the parser samples it once more while
            // it finishes rendering the last real character.
            DRAIN: begin
               if (accept) begin
                  bus.state_enable <= 1'b0;
                  bus.done         <= 1'b1;
                  bus.character    <= '0;
                  bus.rom_addr     <= '0;
                  state            <= DONE;
               end else if (hold != HOLD_LAST) begin
                  hold <= hold + HOLD_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_html_char_streamer.sv
// ----------------------------------------------------------------------------
// tb_html_char_streamer
// Self-checking bench for html_char_streamer. dut_a (DOC_LENGTH=16) covers
// the main stream, pause, empty document and reset cases; dut_b
// (DOC_LENGTH=3) covers the length limit. Each DUT has its own sync ROM.
// ----------------------------------------------------------------------------
module tb_html_char_streamer;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   html_char_streamer_if #(.ADDR_WIDTH(AW)) bus_a ();
   html_char_streamer_if #(.ADDR_WIDTH(AW)) bus_b ();

   html_char_streamer #(.ADDR_WIDTH(AW), .DOC_LENGTH(16), .END_CHAR(8'h00), .MIN_HOLD(2))
      dut_a (.clock(clk), .reset(rst), .bus(bus_a));
   html_char_streamer #(.ADDR_WIDTH(AW), .DOC_LENGTH(3), .END_CHAR(8'h00), .MIN_HOLD(2))
      dut_b (.clock(clk), .reset(rst), .bus(bus_b));

   logic [7:0] mem_a [0:15];
   logic [7:0] mem_b [0:15];

   always_ff @(posedge clk) begin
      bus_a.rom_data <= mem_a[bus_a.rom_addr];
      bus_b.rom_data <= mem_b[bus_b.rom_addr];
   end

   typedef struct {
      logic       start;
      logic       pause;
      logic [7:0] ch;
      logic       se;
      logic       dn;
      logic [4:0] cnt;
      logic [3:0] addr;
   } vec_t;

   vec_t vecs [13];
   int   ntests = 0;
   int   nfail  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_done_a(input int budget, input string name);
      int n;
      n = 0;
      while (bus_a.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(name, {31'd0, bus_a.done}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      logic [7:0] seq [8];
      logic [7:0] prev;
      int         nseq;
      int         n;
      logic       saw_d;

      // "<p>A" then terminator; index: start, pause, char, se, done, count, addr
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 4'd0};
      vecs[1]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 4'd1};
      vecs[2]  = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 4'd1};
      vecs[3]  = '{1'b0, 1'b0, 8'h70, 1'b1, 1'b0, 5'd1, 4'd2};
      vecs[4]  = '{1'b0, 1'b0, 8'h70, 1'b1, 1'b0, 5'd1, 4'd2};
      vecs[5]  = '{1'b0, 1'b0, 8'h3E, 1'b1, 1'b0, 5'd2, 4'd3};
      vecs[6]  = '{1'b0, 1'b0, 8'h3E, 1'b1, 1'b0, 5'd2, 4'd3};
      vecs[7]  = '{1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 5'd3, 4'd4};
      vecs[8]  = '{1'b0, 1'b0, 8'h41, 1'b1, 1'b0, 5'd3, 4'd4};
      vecs[9]  = '{1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 5'd4, 4'd4};
      vecs[10] = '{1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 5'd4, 4'd4};
      vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4, 4'd0};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4, 4'd0};

      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      mem_a[0] = 8'h3C; mem_a[1] = 8'h70; mem_a[2] = 8'h3E; mem_a[3] = 8'h41;
      mem_b[0] = 8'h61; mem_b[1] = 8'h62; mem_b[2] = 8'h63; mem_b[3] = 8'h64;

      rst = 1'b1;
      bus_a.start = 1'b0; bus_a.pause = 1'b0;
      bus_b.start = 1'b0; bus_b.pause = 1'b0;
      tick();
      tick();

      // Reset state
      chk("reset char", {24'd0, bus_a.character}, 32'd0);
      chk("reset state_enable", {31'd0, bus_a.state_enable}, 32'd0);
      chk("reset done", {31'd0, bus_a.done}, 32'd0);
      chk("reset char_count", {27'd0, bus_a.char_count}, 32'd0);
      chk("reset rom_addr", {28'd0, bus_a.rom_addr}, 32'd0);
      rst = 1'b0;

      // Plain stream, no pause
      for (int i = 0; i < 13; i++) begin
         bus_a.start = vecs[i].start;
         bus_a.pause = vecs[i].pause;
         tick();
         chk($sformatf("v%0d char", i), {24'd0, bus_a.character}, {24'd0, vecs[i].ch});
         chk($sformatf("v%0d state_enable", i), {31'd0, bus_a.state_enable}, {31'd0, vecs[i].se});
         chk($sformatf("v%0d done", i), {31'd0, bus_a.done}, {31'd0, vecs[i].dn});
         chk($sformatf("v%0d char_count", i), {27'd0, bus_a.char_count}, {27'd0, vecs[i].cnt});
         chk($sformatf("v%0d rom_addr", i), {28'd0, bus_a.rom_addr}, {28'd0, vecs[i].addr});
      end

      // Pause while 'p' is shown; start pulse mid-stream is ignored
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      chk("restart done cleared", {31'd0, bus_a.done}, 32'd0);
      tick();
      chk("restart first char", {24'd0, bus_a.character}, 32'h3C);
      tick();
      tick();
      chk("pause pre char", {24'd0, bus_a.character}, 32'h70);
      bus_a.pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus_a.start = (k == 5);
         tick();
         chk($sformatf("pause%0d char", k), {24'd0, bus_a.character}, 32'h70);
         chk($sformatf("pause%0d rom_addr", k), {28'd0, bus_a.rom_addr}, 32'd2);
      end
      bus_a.start = 1'b0;
      bus_a.pause = 1'b0;
      tick();
      chk("pause release char", {24'd0, bus_a.character}, 32'h3E);
      wait_done_a(40, "pause doc done");
      chk("pause doc char_count", {27'd0, bus_a.char_count}, 32'd4);
      chk("pause doc state_enable", {31'd0, bus_a.state_enable}, 32'd0);
      chk("pause doc char", {24'd0, bus_a.character}, 32'd0);

      // Empty document
      mem_a[0] = 8'h00;
      tick();
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      chk("empty done after 1", {31'd0, bus_a.done}, 32'd0);
      chk("empty se after 1", {31'd0, bus_a.state_enable}, 32'd0);
      tick();
      chk("empty done after 2", {31'd0, bus_a.done}, 32'd1);
      chk("empty se after 2", {31'd0, bus_a.state_enable}, 32'd0);
      chk("empty char_count", {27'd0, bus_a.char_count}, 32'd0);

      // Reset mid-document at 'b', then replay
      mem_a[0] = 8'h61; mem_a[1] = 8'h62; mem_a[2] = 8'h63; mem_a[3] = 8'h00;
      tick();
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      n = 0;
      while (bus_a.character !== 8'h62 && n < 20) begin
         tick();
         n++;
      end
      chk("reach b", {24'd0, bus_a.character}, 32'h62);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midreset state_enable", {31'd0, bus_a.state_enable}, 32'd0);
      chk("midreset char", {24'd0, bus_a.character}, 32'd0);
      chk("midreset rom_addr", {28'd0, bus_a.rom_addr}, 32'd0);
      chk("midreset done", {31'd0, bus_a.done}, 32'd0);
      chk("midreset char_count", {27'd0, bus_a.char_count}, 32'd0);
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      tick();
      chk("replay first char", {24'd0, bus_a.character}, 32'h61);
      chk("replay state_enable", {31'd0, bus_a.state_enable}, 32'd1);
      wait_done_a(40, "replay done");
      chk("replay char_count", {27'd0, bus_a.char_count}, 32'd3);

      // Reset and start together stay in IDLE
      rst = 1'b1;
      bus_a.start = 1'b1;
      tick();
      rst = 1'b0;
      bus_a.start = 1'b0;
      tick();
      tick();
      chk("rst+start state_enable", {31'd0, bus_a.state_enable}, 32'd0);
      chk("rst+start done", {31'd0, bus_a.done}, 32'd0);
      chk("rst+start char", {24'd0, bus_a.character}, 32'd0);

      // Length limit on dut_b: only 'a','b','c'
      nseq  = 0;
      saw_d = 1'b0;
      prev  = 8'h00;
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      n = 0;
      while (bus_b.done !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (bus_b.character === 8'h64) saw_d = 1'b1;
         if (bus_b.character !== prev && bus_b.character !== 8'h00 &&
             bus_b.character !== 8'h20 && nseq < 8) begin
            seq[nseq] = bus_b.character;
            nseq++;
         end
         prev = bus_b.character;
      end
      chk("len done", {31'd0, bus_b.done}, 32'd1);
      chk("len chars presented", nseq, 32'd3);
      chk("len char0", {24'd0, seq[0]}, 32'h61);
      chk("len char1", {24'd0, seq[1]}, 32'h62);
      chk("len char2", {24'd0, seq[2]}, 32'h63);
      chk("len no d", {31'd0, saw_d}, 32'd0);
      chk("len char_count", {27'd0, bus_b.char_count}, 32'd3);
      chk("len state_enable", {31'd0, bus_b.state_enable}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
